// File: rtl/aes_tb_pkg.sv
// Shared constants for the ROM-driven AES test harness: FSM encoding and block geometry.
package aes_tb_pkg;

  localparam int BYTES_PER_BLOCK = 16;
  localparam int BLOCK_W         = 128;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] LOAD    = 2'b01;
  localparam logic [1:0] PRESENT = 2'b10;
  localparam logic [1:0] DONE    = 2'b11;

endpackage

// File: rtl/block_assembler.sv
// 128-bit MSB-first byte shift register plus 4-bit byte counter; last_byte marks the capture at index 15.
module block_assembler
  import aes_tb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [7:0]         rom_data,
  output logic [3:0]         byte_cnt,
  output logic [BLOCK_W-1:0] block,
  output logic               last_byte
);

  logic [3:0]         cnt_q, cnt_d;
  logic [BLOCK_W-1:0] block_q, block_d;

  always_comb begin
    cnt_d   = cnt_q;
    block_d = block_q;
    if (clr) begin
      cnt_d = '0;
    end else if (shift_en) begin
      // byte 0 ends up in the top byte after 16 shifts
      block_d = {block_q[BLOCK_W-9:0], rom_data};
      cnt_d   = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  end

  assign byte_cnt  = cnt_q;
  assign block     = block_q;
  assign last_byte = shift_en && (cnt_q == 4'(BYTES_PER_BLOCK - 1));

endmodule

// File: rtl/rom_block_loader.sv
// Streams NUM_VECTORS 16-byte ROM vectors as 128-bit blocks over valid/ready after one start pulse.
// ROM_LOADER_WRAP_EN: after the last vector wrap to vector 0 instead of stopping in DONE.
module rom_block_loader
  import aes_tb_pkg::*;
#(
  parameter int NUM_VECTORS = 512,
  parameter int DEPTH_W     = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         rom_data,
  output logic [3:0]         rom_byte_addr,
  output logic [DEPTH_W-1:0] rom_vec_addr,
  output logic [BLOCK_W-1:0] block_out,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               busy,
  output logic               done
);

  localparam logic [DEPTH_W-1:0] LAST_VEC = DEPTH_W'(NUM_VECTORS - 1);

  logic [1:0]         state_q, state_d;
  logic [DEPTH_W-1:0] vec_q, vec_d;
  logic               valid_q, valid_d;
  logic               start_ok, xfer, last_byte;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign xfer     = valid_q && block_ready;

  block_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .shift_en  (state_q == LOAD),
    .rom_data  (rom_data),
    .byte_cnt  (rom_byte_addr),
    .block     (block_out),
    .last_byte (last_byte)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          vec_d   = '0;
        end
      end
      LOAD: begin
        if (last_byte) state_d = PRESENT;
      end
      PRESENT: begin
        if (xfer) begin
          if (vec_q != LAST_VEC) begin
            vec_d   = vec_q + DEPTH_W'(1);
            state_d = LOAD;
          end else begin
`ifdef ROM_LOADER_WRAP_EN
            vec_d   = '0;
            state_d = LOAD;
`else
            state_d = DONE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  assign rom_vec_addr = vec_q;
  assign block_valid  = valid_q;
  assign busy         = (state_q == LOAD) || (state_q == PRESENT);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_rom_block_loader.sv
// Directed bench: NUM_VECTORS=3 main instance plus a NUM_VECTORS=1 instance sharing the controls.
module tb_rom_block_loader;

  localparam logic [127:0] VEC0 = 128'h00112233445566778899aabbccddeeff;

  logic         clk, rst, start, block_ready;
  logic [7:0]   rom_data, one_rom_data;
  logic [3:0]   rom_byte_addr, one_byte_addr;
  logic [1:0]   rom_vec_addr;
  logic [0:0]   one_vec_addr;
  logic [127:0] block_out, one_block_out;
  logic         block_valid, busy, done;
  logic         one_valid, one_busy, one_done;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] rom_byte(input int v, input int b);
    return 8'((b * 17) ^ (v * 8'h5A));
  endfunction

  function automatic logic [127:0] exp_block(input int v);
    logic [127:0] blk = '0;
    for (int b = 0; b < 16; b++) blk = {blk[119:0], rom_byte(v, b)};
    return blk;
  endfunction

  assign rom_data     = rom_byte(int'(rom_vec_addr), int'(rom_byte_addr));
  assign one_rom_data = rom_byte(int'(one_vec_addr), int'(one_byte_addr));

  rom_block_loader #(.NUM_VECTORS(3), .DEPTH_W(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .rom_data(rom_data),
    .rom_byte_addr(rom_byte_addr), .rom_vec_addr(rom_vec_addr),
    .block_out(block_out), .block_valid(block_valid), .block_ready(block_ready),
    .busy(busy), .done(done)
  );

  rom_block_loader #(.NUM_VECTORS(1), .DEPTH_W(1)) u_one (
    .clk(clk), .rst(rst), .start(start), .rom_data(one_rom_data),
    .rom_byte_addr(one_byte_addr), .rom_vec_addr(one_vec_addr),
    .block_out(one_block_out), .block_valid(one_valid), .block_ready(block_ready),
    .busy(one_busy), .done(one_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte"},  128'(rom_byte_addr), 128'd0);
    check({tag, "_vec"},   128'(rom_vec_addr),  128'd0);
    check({tag, "_block"}, block_out,           128'd0);
    check({tag, "_valid"}, 128'(block_valid),   128'd0);
    check({tag, "_busy"},  128'(busy),          128'd0);
    check({tag, "_done"},  128'(done),          128'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; block_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 128'(busy), 128'd0);

    // Vector 0: start, walk bytes 0..15 with a stray start at byte 7
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("v0_byte%0d", i), 128'(rom_byte_addr), 128'(i));
      check($sformatf("v0_novalid%0d", i), 128'(block_valid), 128'd0);
      start = (i == 7);
      @(negedge clk);
    end
    start = 1'b0;
    check("v0_valid", 128'(block_valid), 128'd1);
    check("v0_block", block_out, VEC0);
    check("v0_vec", 128'(rom_vec_addr), 128'd0);
    check("one_valid", 128'(one_valid), 128'd1);

    // Transfer of vector 0; apply backpressure to vector 1
    @(negedge clk);
    check("x0_valid", 128'(block_valid), 128'd0);
    check("x0_vec", 128'(rom_vec_addr), 128'd1);
    check("x0_byte", 128'(rom_byte_addr), 128'd0);
`ifdef ROM_LOADER_WRAP_EN
    check("one_wrap_done", 128'(one_done), 128'd0);
    check("one_wrap_vec", 128'(one_vec_addr), 128'd0);
`else
    check("one_done", 128'(one_done), 128'd1);
    check("one_busy", 128'(one_busy), 128'd0);
    check("one_block", one_block_out, VEC0);
`endif
    block_ready = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid%0d", i), 128'(block_valid), 128'd1);
      check($sformatf("bp_block%0d", i), block_out, exp_block(1));
      check($sformatf("bp_vec%0d", i), 128'(rom_vec_addr), 128'd1);
      @(negedge clk);
    end
    block_ready = 1'b1;
    @(negedge clk);
    check("x1_valid", 128'(block_valid), 128'd0);
    check("x1_vec", 128'(rom_vec_addr), 128'd2);
    check("x1_busy", 128'(busy), 128'd1);

    // Vector 2 is the last one
    repeat (16) @(negedge clk);
    check("v2_valid", 128'(block_valid), 128'd1);
    check("v2_block", block_out, exp_block(2));
    check("v2_vec", 128'(rom_vec_addr), 128'd2);
    @(negedge clk);
`ifdef ROM_LOADER_WRAP_EN
    check("wrap_vec", 128'(rom_vec_addr), 128'd0);
    check("wrap_valid", 128'(block_valid), 128'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("wrap_nodone%0d", i), 128'(done), 128'd0);
      @(negedge clk);
    end
    check("wrap_v0_valid", 128'(block_valid), 128'd1);
    check("wrap_v0_block", block_out, VEC0);
    check("wrap_v0_vec", 128'(rom_vec_addr), 128'd0);
`else
    for (int i = 0; i < 4; i++) begin
      check($sformatf("done%0d", i), 128'(done), 128'd1);
      check($sformatf("done_busy%0d", i), 128'(busy), 128'd0);
      check($sformatf("done_valid%0d", i), 128'(block_valid), 128'd0);
      @(negedge clk);
    end
    check("done_block", block_out, exp_block(2));
    check("done_vec", 128'(rom_vec_addr), 128'd2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_busy", 128'(busy), 128'd1);
    check("restart_done", 128'(done), 128'd0);
    check("restart_vec", 128'(rom_vec_addr), 128'd0);
    check("restart_byte", 128'(rom_byte_addr), 128'd0);
`endif

    // Clean restart, then asynchronous reset at byte 9 of vector 1
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("r_v0_valid", 128'(block_valid), 128'd1);
    @(negedge clk);
    repeat (9) @(negedge clk);
    check("r_byte9", 128'(rom_byte_addr), 128'd9);
    check("r_vec1", 128'(rom_vec_addr), 128'd1);
    #2 rst = 1'b0;
    #1 check_reset_vals("async");
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_vec", 128'(rom_vec_addr), 128'd0);
    repeat (16) @(negedge clk);
    check("post_valid", 128'(block_valid), 128'd1);
    check("post_block", block_out, VEC0);
    check("post_vec0", 128'(rom_vec_addr), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
